// File: rtl/karatsuba_pkg.sv
// Shared widths and FSM state type for the sequential Karatsuba multiplier.
package karatsuba_pkg;

  localparam int HALF_W = 4;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 16;
  localparam int D_W    = HALF_W + 1;
  localparam int A_W    = 2 * HALF_W;
  localparam int C_W    = 2 * D_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_A   = 3'd1,
    MUL_B   = 3'd2,
    MUL_C   = 3'd3,
    COMBINE = 3'd4,
    DONE    = 3'd5
  } kstate_t;

endpackage

// File: rtl/karatsuba_seq_mult_d_factor.sv
// D_factor: sum of the high and low halves of an 8-bit operand (5-bit result).
module D_factor
  import karatsuba_pkg::*;
(
  input  logic [IN_W-1:0] x,
  output logic [D_W-1:0]  d
);

  assign d = {1'b0, x[IN_W-1:HALF_W]} + {1'b0, x[HALF_W-1:0]};

endmodule

// File: rtl/karatsuba_seq_mult.sv
// Sequential 8x8 unsigned Karatsuba multiplier with a start/done handshake.
// Optional reference-multiplier self-check: define KARATSUBA_SELFCHECK_EN.
module karatsuba_seq_mult
  import karatsuba_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  X,
  input  logic [IN_W-1:0]  Y,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] P,
  output logic             mismatch
);

  kstate_t state_q, state_d;

  logic [IN_W-1:0]  x_q, y_q;
  logic [A_W-1:0]   a_q, b_q;
  logic [C_W-1:0]   c_q;
  logic [OUT_W-1:0] p_q;

  logic [D_W-1:0]   dx, dy;
  logic [D_W-1:0]   mul_l, mul_r;
  logic [C_W-1:0]   mul_p;
  logic [C_W-1:0]   m_val;
  logic [OUT_W-1:0] p_comb;
  logic             accept;

  D_factor u_dx (.x(x_q), .d(dx));
  D_factor u_dy (.x(y_q), .d(dy));

  assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MUL_A;
      MUL_A:   state_d = MUL_B;
      MUL_B:   state_d = MUL_C;
      MUL_C:   state_d = COMBINE;
      COMBINE: state_d = DONE;
      DONE:    state_d = start ? MUL_A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One 5x5 multiplier shared across the three partial-product cycles
  always_comb begin
    mul_l = '0;
    mul_r = '0;
    case (state_q)
      MUL_A: begin
        mul_l = {1'b0, x_q[IN_W-1:HALF_W]};
        mul_r = {1'b0, y_q[IN_W-1:HALF_W]};
      end
      MUL_B: begin
        mul_l = {1'b0, x_q[HALF_W-1:0]};
        mul_r = {1'b0, y_q[HALF_W-1:0]};
      end
      MUL_C: begin
        mul_l = dx;
        mul_r = dy;
      end
      default: begin
        mul_l = '0;
        mul_r = '0;
      end
    endcase
  end

  assign mul_p  = C_W'(mul_l) * C_W'(mul_r);
  assign m_val  = c_q - {2'b00, a_q} - {2'b00, b_q};
  assign p_comb = {a_q, 8'h00} + {2'b00, m_val, 4'h0} + {8'h00, b_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      p_q <= '0;
    end else begin
      if (accept) begin
        x_q <= X;
        y_q <= Y;
      end
      if (state_q == MUL_A)   a_q <= mul_p[A_W-1:0];
      if (state_q == MUL_B)   b_q <= mul_p[A_W-1:0];
      if (state_q == MUL_C)   c_q <= mul_p;
      if (state_q == COMBINE) p_q <= p_comb;
    end
  end

`ifdef KARATSUBA_SELFCHECK_EN
  logic [OUT_W-1:0] ref_p;
  logic             mismatch_q;

  assign ref_p = OUT_W'(x_q) * OUT_W'(y_q);

  // Sticky until reset so a single bad result is never lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          mismatch_q <= 1'b0;
    else if ((state_q == COMBINE) && (ref_p != p_comb)) mismatch_q <= 1'b1;
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign busy = (state_q == MUL_A) || (state_q == MUL_B) ||
                (state_q == MUL_C) || (state_q == COMBINE);
  assign done = (state_q == DONE);
  assign P    = p_q;

endmodule
